pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central sequencer for the four pipeline registers of the 5-stage CPU: IF/ID, ID/EX, EX/MEM and MEM/WB, each a flopenrc instance.
- Drives every stage register's en and clear, plus the PC stall.
- Resolves four conditions: load-use hazards, taken-branch flushes, multi-cycle data-memory waits with a watchdog timeout, and a post-reset pipeline scrub.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_W, 5, register index width.
- INIT_CYCLES, 4, cycles of full-pipeline clear after reset release (must be ≥ 1).
- MEM_TIMEOUT, 16, maximum consecutive cycles MEM_WAIT may last before an abort.
- COUNT_W, 16, width of the stall counter.

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- reset, in, 1, synchronous, active-high.
- rs1_d, in, REG_W, source register 1 of the instruction in Decode.
- rs2_d, in, REG_W, source register 2 of the instruction in Decode.
- rd_e, in, REG_W, destination register of the instruction in Execute.
- memread_e, in, 1, the instruction in Execute is a load.
- pcsrc_e, in, 1, a branch or jump in Execute is taken.
- mem_req_m, in, 1, the Memory stage has a data-memory access in flight.
- mem_ack, in, 1, data memory completes the access this cycle.
- stall_f, out, 1, hold the PC.
- en_fd, out, 1, enable for IF/ID. clr_fd, out, 1, clear for IF/ID.
- en_de, out, 1, enable for ID/EX. clr_de, out, 1, clear for ID/EX.
- en_em, out, 1, enable for EX/MEM. clr_em, out, 1, clear for EX/MEM.
- en_mw, out, 1, enable for MEM/WB. clr_mw, out, 1, clear for MEM/WB.
- mem_err, out, 1, registered one-cycle pulse when a memory access is aborted on timeout.
- stall_count, out, COUNT_W, saturating count of stall cycles.

Behaviour:
- States:
  - INIT: entered on reset; stays INIT_CYCLES cycles, then goes to RUN.
  - RUN: goes to MEM_WAIT when mem_req_m=1 and mem_ack=0.
  - MEM_WAIT: goes to RUN on mem_ack=1 or on timeout.
- Reset:
  - state=INIT, init counter=0, wait counter=0, mem_err=0, stall_count=0.
  - A reset asserted mid-MEM_WAIT aborts the wait without a mem_err pulse.
- INIT outputs: all en_*=1, all clr_*=1, stall_f=1, so bubbles propagate through every stage.
- Hazard terms, all combinational, same-cycle (0 latency):
  - lu = memread_e & (rd_e≠0) & (rd_e==rs1_d | rd_e==rs2_d).
  - mw = mem_req_m & ~mem_ack, in either RUN or MEM_WAIT.
- Output priority in RUN/MEM_WAIT, highest first:
  1. Timeout: the wait counter reaches MEM_TIMEOUT-1 while mw=1.
     - en_em=1 and clr_em=1 (kills the access); en_mw=1 and clr_mw=1.
     - Upstream stages are held: stall_f=1, en_fd=0, en_de=0.
     - mem_err pulses on the next cycle; state goes to RUN.
  2. mw=1 (memory wait):
     - stall_f=1; en_fd, en_de, en_em all 0; no upstream clears.
     - en_mw=1, clr_mw=1: a bubble enters Writeback.
     - pcsrc_e and lu are ignored this cycle; they are re-evaluated once the wait ends because Execute is held.
  3. pcsrc_e=1: clr_fd=1, clr_de=1, all en=1, stall_f=0. A branch overrides lu, since the loading dependent is flushed anyway.
  4. lu=1: stall_f=1, en_fd=0, en_de=1 with clr_de=1 (one bubble); later stages enabled.
  5. Otherwise: all en=1, all clr=0, stall_f=0.
- Wait counter:
  - Increments each mw cycle.
  - Clears on mem_ack, on timeout, or in RUN when mw=0.
  - A mem_ack arriving exactly on the timeout cycle takes precedence: normal completion, no mem_err.
- stall_count: +1 on every RUN/MEM_WAIT cycle with stall_f=1; saturates at all-ones and does not wrap. INIT cycles are not counted.
- Invariant: en_x=0 implies clr_x=0. A held register is never also cleared.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - the state enum {INIT, RUN, MEM_WAIT};
  - the default parameter constants;
  - a struct bundling the en/clr pair of one stage.
- One sub-module, hazard_detect: the combinational lu equation, reusable by the forwarding unit.
- The FSM, counters and priority mux stay in pipeline_ctrl.

Test Plan:
1. Reset 1 cycle, then release. All clr_*=1 and stall_f=1 for exactly 4 cycles, then all en=1, all clr=0; stall_count=0.
2. Load-use: memread_e=1, rd_e=5, rs1_d=5. Same cycle stall_f=1, en_fd=0, clr_de=1; stall_count=1. With rd_e=0 instead, there is no stall.
3. Load-use and branch together: memread_e=1, rd_e=3, rs2_d=3, pcsrc_e=1. Flush wins: clr_fd=1, clr_de=1, stall_f=0; stall_count unchanged.
4. Memory wait: mem_req_m=1, mem_ack arrives on the 3rd cycle. en_fd, en_de, en_em=0 and clr_mw=1 for 2 cycles, normal outputs on the ack cycle; stall_count=2; mem_err never asserted.
5. Timeout: mem_req_m=1, mem_ack held 0. On cycle 16, clr_em=1 and en_em=1; mem_err=1 on cycle 17 for exactly 1 cycle; state returns to RUN. Repeat with mem_ack=1 on cycle 16: no mem_err.
6. Saturation with COUNT_W=4: force 20 stall cycles. stall_count reaches 15 and stays 15; reset mid-MEM_WAIT returns stall_count=0 and restarts INIT.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state enum, default parameters and stage control bundle
package pipeline_ctrl_pkg;
  localparam int DEF_REG_W       = 5;
  localparam int DEF_INIT_CYCLES = 4;
  localparam int DEF_MEM_TIMEOUT = 16;
  localparam int DEF_COUNT_W     = 16;
  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;
  typedef struct packed {
    logic en;
    logic clr;
  } stage_ctrl_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use dependency between Execute load and Decode sources
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rd_e,
  input  logic             memread_e,
  output logic             lu
);
  assign lu = memread_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the four pipeline registers with init scrub and memory watchdog
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W       = DEF_REG_W,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int COUNT_W     = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_W-1:0]   rs1_d,
  input  logic [REG_W-1:0]   rs2_d,
  input  logic [REG_W-1:0]   rd_e,
  input  logic               memread_e,
  input  logic               pcsrc_e,
  input  logic               mem_req_m,
  input  logic               mem_ack,
  output logic               stall_f,
  output logic               en_fd,
  output logic               clr_fd,
  output logic               en_de,
  output logic               clr_de,
  output logic               en_em,
  output logic               clr_em,
  output logic               en_mw,
  output logic               clr_mw,
  output logic               mem_err,
  output logic [COUNT_W-1:0] stall_count
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t        state, state_nxt;
  logic [IW-1:0] init_cnt;
  logic [WW-1:0] wait_cnt;
  logic          lu, mem_wait, to, init;
  stage_ctrl_t   s_fd, s_de, s_em, s_mw;
  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e), .memread_e(memread_e), .lu(lu)
  );
  assign init     = (state == INIT);
  assign mem_wait = mem_req_m & ~mem_ack;
  assign to       = ~init & mem_wait & (wait_cnt == WW'(MEM_TIMEOUT - 1));
  always_comb begin
    state_nxt = state;
    stall_f   = 1'b0;
    s_fd      = '{1'b1, 1'b0};
    s_de      = '{1'b1, 1'b0};
    s_em      = '{1'b1, 1'b0};
    s_mw      = '{1'b1, 1'b0};
    if (init) begin
      state_nxt = (init_cnt == IW'(INIT_CYCLES - 1)) ? RUN : INIT;
      stall_f   = 1'b1;
      s_fd      = '{1'b1, 1'b1};
      s_de      = '{1'b1, 1'b1};
      s_em      = '{1'b1, 1'b1};
      s_mw      = '{1'b1, 1'b1};
    end else begin
      state_nxt = (state == RUN) ? ((mem_wait & ~to) ? MEM_WAIT : RUN)
                                 : ((mem_ack | to) ? RUN : MEM_WAIT);
      if (to | mem_wait) begin
        stall_f = 1'b1;
        s_fd    = '{1'b0, 1'b0};
        s_de    = '{1'b0, 1'b0};
        s_em    = to ? '{1'b1, 1'b1} : '{1'b0, 1'b0};
        s_mw    = '{1'b1, 1'b1};
      end else if (pcsrc_e) begin
        s_fd = '{1'b1, 1'b1};
        s_de = '{1'b1, 1'b1};
      end else if (lu) begin
        stall_f = 1'b1;
        s_fd    = '{1'b0, 1'b0};
        s_de    = '{1'b1, 1'b1};
      end
    end
  end
  assign {en_fd, clr_fd} = s_fd;
  assign {en_de, clr_de} = s_de;
  assign {en_em, clr_em} = s_em;
  assign {en_mw, clr_mw} = s_mw;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      init_cnt    <= '0;
      wait_cnt    <= '0;
      mem_err     <= 1'b0;
      stall_count <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init ? init_cnt + 1'b1 : init_cnt;
      wait_cnt <= (~init & mem_wait & ~to) ? wait_cnt + 1'b1 : '0;
      mem_err  <= to;
      if (~init & stall_f & ~&stall_count)
        stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors for pipeline_ctrl, plus a 4-bit-counter copy for saturation
module tb_pipeline_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs1_d = '0, rs2_d = '0, rd_e = '0;
  logic        memread_e = 1'b0, pcsrc_e = 1'b0, mem_req_m = 1'b0, mem_ack = 1'b0;
  logic        stall_f, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw, mem_err;
  logic        s_stall_f, s_en_fd, s_clr_fd, s_en_de, s_clr_de, s_en_em, s_clr_em, s_en_mw, s_clr_mw, s_mem_err;
  logic [15:0] stall_count;
  logic [3:0]  sat_count;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  pipeline_ctrl dut (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
    .memread_e(memread_e), .pcsrc_e(pcsrc_e), .mem_req_m(mem_req_m), .mem_ack(mem_ack),
    .stall_f(stall_f), .en_fd(en_fd), .clr_fd(clr_fd), .en_de(en_de), .clr_de(clr_de),
    .en_em(en_em), .clr_em(clr_em), .en_mw(en_mw), .clr_mw(clr_mw),
    .mem_err(mem_err), .stall_count(stall_count)
  );
  pipeline_ctrl #(.COUNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
    .memread_e(memread_e), .pcsrc_e(pcsrc_e), .mem_req_m(mem_req_m), .mem_ack(mem_ack),
    .stall_f(s_stall_f), .en_fd(s_en_fd), .clr_fd(s_clr_fd), .en_de(s_en_de), .clr_de(s_clr_de),
    .en_em(s_en_em), .clr_em(s_clr_em), .en_mw(s_en_mw), .clr_mw(s_clr_mw),
    .mem_err(s_mem_err), .stall_count(sat_count)
  );
  // {mem_err, stall_f, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw}
  localparam logic [9:0] V_INIT = 10'b0_1_11_11_11_11;
  localparam logic [9:0] V_NORM = 10'b0_0_10_10_10_10;
  localparam logic [9:0] V_LU   = 10'b0_1_00_11_10_10;
  localparam logic [9:0] V_BR   = 10'b0_0_11_11_10_10;
  localparam logic [9:0] V_MW   = 10'b0_1_00_00_00_11;
  localparam logic [9:0] V_TO   = 10'b0_1_00_00_11_11;
  localparam logic [9:0] V_ERR  = 10'b1_0_10_10_10_10;
  wire [9:0] ctl = {mem_err, stall_f, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [9:0] exp);
    @(negedge clk);
    chk(tag, {22'd0, ctl}, {22'd0, exp});
    @(posedge clk);
    #1;
  endtask
  task automatic counts(input string tag, input int exp);
    chk({tag, "_cnt"}, {16'd0, stall_count}, exp);
    chk({tag, "_sat"}, {28'd0, sat_count}, (exp > 15) ? 15 : exp);
  endtask
  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) step("init", V_INIT);
    step("run_idle", V_NORM);
    counts("after_init", 0);
    memread_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
    step("load_use", V_LU);
    counts("load_use", 1);
    rd_e = 5'd0; rs1_d = 5'd0;
    step("lu_rd0", V_NORM);
    counts("lu_rd0", 1);
    rd_e = 5'd3; rs2_d = 5'd3; pcsrc_e = 1'b1;
    step("br_over_lu", V_BR);
    counts("br_over_lu", 1);
    memread_e = 1'b0; rd_e = '0; rs2_d = '0; pcsrc_e = 1'b0;
    mem_req_m = 1'b1;
    step("mwait1", V_MW);
    step("mwait2", V_MW);
    mem_ack = 1'b1;
    step("mack", V_NORM);
    mem_req_m = 1'b0; mem_ack = 1'b0;
    step("mack_after", V_NORM);
    counts("mwait", 3);
    mem_req_m = 1'b1;
    for (int i = 0; i < 15; i++) step("to_wait", V_MW);
    step("timeout", V_TO);
    mem_req_m = 1'b0;
    step("mem_err", V_ERR);
    step("mem_err_gone", V_NORM);
    counts("timeout", 19);
    mem_req_m = 1'b1;
    for (int i = 0; i < 15; i++) step("ack16_wait", V_MW);
    mem_ack = 1'b1;
    step("ack16", V_NORM);
    mem_req_m = 1'b0; mem_ack = 1'b0;
    step("ack16_noerr", V_NORM);
    counts("ack16", 34);
    mem_req_m = 1'b1;
    step("rst_wait1", V_MW);
    step("rst_wait2", V_MW);
    counts("rst_wait", 36);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    counts("mid_reset", 0);
    for (int i = 0; i < 4; i++) step("reinit", V_INIT);
    mem_req_m = 1'b0;
    step("rerun", V_NORM);
    counts("rerun", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
